// File: rtl/mem_access_unit.sv
// Load/store unit between the core's LSU request and a doubleword memory port.
// Handles alignment faults, byte-lane steering, load extension and an ack timeout.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ls_valid,
    input  logic        ls_we,
    input  logic [2:0]  ls_funct3,
    input  logic [63:0] ls_addr,
    input  logic [63:0] ls_wdata,
    output logic        ls_done,
    output logic [63:0] ls_rdata,
    output logic        ls_stall,
    output logic [1:0]  ls_fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic            we_q;
    logic [2:0]      funct3_q;
    logic [2:0]      off_q;

    logic            misaligned;
    logic [7:0]      wmask_base;
    logic [7:0]      wmask_new;
    logic [63:0]     wdata_new;
    logic [63:0]     rdata_sh;
    logic [63:0]     load_ext;

    // Width comes from funct3[1:0] for both loads and stores; 111 is not a legal load.
    always_comb begin
        misaligned = 1'b0;
        wmask_base = 8'h01;
        case (ls_funct3[1:0])
            2'b00: begin
                misaligned = 1'b0;
                wmask_base = 8'h01;
            end
            2'b01: begin
                misaligned = ls_addr[0];
                wmask_base = 8'h03;
            end
            2'b10: begin
                misaligned = |ls_addr[1:0];
                wmask_base = 8'h0F;
            end
            default: begin
                misaligned = |ls_addr[2:0];
                wmask_base = 8'hFF;
            end
        endcase
        if (!ls_we && (ls_funct3 == 3'b111)) begin
            misaligned = 1'b1;
        end
        wmask_new = ls_we ? (wmask_base << ls_addr[2:0]) : 8'h00;
        wdata_new = ls_wdata << {ls_addr[2:0], 3'b000};
    end

    always_comb begin
        rdata_sh = mem_rdata >> {off_q, 3'b000};
        load_ext = 64'h0;
        case (funct3_q)
            3'b000:  load_ext = {{56{rdata_sh[7]}}, rdata_sh[7:0]};
            3'b001:  load_ext = {{48{rdata_sh[15]}}, rdata_sh[15:0]};
            3'b010:  load_ext = {{32{rdata_sh[31]}}, rdata_sh[31:0]};
            3'b011:  load_ext = rdata_sh;
            3'b100:  load_ext = {56'h0, rdata_sh[7:0]};
            3'b101:  load_ext = {48'h0, rdata_sh[15:0]};
            3'b110:  load_ext = {32'h0, rdata_sh[31:0]};
            default: load_ext = 64'h0;
        endcase
    end

    assign cnt_d    = cnt_q + 1'b1;
    assign ls_stall = ((state_q == StIdle) && ls_valid) || (state_q == StReq);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            funct3_q  <= 3'b000;
            off_q     <= 3'b000;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 64'h0;
            mem_wdata <= 64'h0;
            mem_wmask <= 8'h00;
            ls_done   <= 1'b0;
            ls_rdata  <= 64'h0;
            ls_fault  <= 2'b00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ls_valid) begin
                        if (misaligned) begin
                            state_q  <= StDone;
                            ls_done  <= 1'b1;
                            ls_fault <= 2'b01;
                            ls_rdata <= 64'h0;
                        end else begin
                            state_q   <= StReq;
                            cnt_q     <= '0;
                            we_q      <= ls_we;
                            funct3_q  <= ls_funct3;
                            off_q     <= ls_addr[2:0];
                            mem_req   <= 1'b1;
                            mem_we    <= ls_we;
                            mem_addr  <= {ls_addr[63:3], 3'b000};
                            mem_wdata <= wdata_new;
                            mem_wmask <= wmask_new;
                        end
                    end
                end
                StReq: begin
                    // An ack in the final counted cycle still completes cleanly.
                    if (mem_ack) begin
                        state_q  <= StDone;
                        mem_req  <= 1'b0;
                        ls_done  <= 1'b1;
                        ls_fault <= 2'b00;
                        ls_rdata <= we_q ? 64'h0 : load_ext;
                    end else if (cnt_d == CntW'(TIMEOUT)) begin
                        state_q  <= StDone;
                        cnt_q    <= cnt_d;
                        mem_req  <= 1'b0;
                        ls_done  <= 1'b1;
                        ls_fault <= 2'b10;
                        ls_rdata <= 64'h0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                StDone: begin
                    state_q  <= StIdle;
                    ls_done  <= 1'b0;
                    ls_fault <= 2'b00;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a scoreboard of expected completions is
// checked on every ls_done, with direct checks on the memory-side outputs.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ls_valid;
    logic        ls_we;
    logic [2:0]  ls_funct3;
    logic [63:0] ls_addr;
    logic [63:0] ls_wdata;
    logic        ls_done;
    logic [63:0] ls_rdata;
    logic        ls_stall;
    logic [1:0]  ls_fault;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    typedef struct packed {
        logic [63:0] rdata;
        logic [1:0]  fault;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic        cap_req;
    logic        cap_we;
    logic [63:0] cap_addr;
    logic [63:0] cap_wdata;
    logic [7:0]  cap_wmask;
    logic        done_req;
    int          stall_cnt;
    int          done_at;

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .ls_valid  (ls_valid),
        .ls_we     (ls_we),
        .ls_funct3 (ls_funct3),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_done   (ls_done),
        .ls_rdata  (ls_rdata),
        .ls_stall  (ls_stall),
        .ls_fault  (ls_fault),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every completion must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rstn === 1'b1 && ls_done === 1'b1) begin
            chk("sb_pending", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_rdata", ls_rdata, e.rdata);
                chk("sb_fault", 64'(ls_fault), 64'(e.fault));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts just after a rising edge in IDLE, ends on the falling edge of the done cycle.
    task automatic run_access(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                              input logic [63:0] wdata, input int ack_after,
                              input logic [63:0] rdata, input logic [63:0] exp_rdata,
                              input logic [1:0] exp_fault);
        bit seen;
        sb.push_back('{rdata: exp_rdata, fault: exp_fault});
        ls_we     = we;
        ls_funct3 = f3;
        ls_addr   = addr;
        ls_wdata  = wdata;
        mem_rdata = rdata;
        stall_cnt = 0;
        done_at   = -1;
        seen      = 1'b0;
        for (int i = 0; i < 12; i++) begin
            ls_valid = (i == 0);
            mem_ack  = (ack_after > 0) && (i == ack_after);
            @(negedge clk);
            if (ls_stall === 1'b1) stall_cnt++;
            if (i == 1) begin
                cap_req   = mem_req;
                cap_we    = mem_we;
                cap_addr  = mem_addr;
                cap_wdata = mem_wdata;
                cap_wmask = mem_wmask;
            end
            if (ls_done === 1'b1) begin
                done_at  = i;
                done_req = mem_req;
                seen     = 1'b1;
                break;
            end
            step();
        end
        mem_ack  = 1'b0;
        ls_valid = 1'b0;
        chk("done_seen", 64'(seen), 64'd1);
    endtask

    initial begin
        rstn      = 1'b0;
        ls_valid  = 1'b0;
        ls_we     = 1'b0;
        ls_funct3 = 3'b000;
        ls_addr   = 64'h0;
        ls_wdata  = 64'h0;
        mem_ack   = 1'b0;
        mem_rdata = 64'h0;
        step();
        step();
        @(negedge clk);
        chk("rst_done", 64'(ls_done), 64'd0);
        chk("rst_req", 64'(mem_req), 64'd0);
        chk("rst_rdata", ls_rdata, 64'h0);
        chk("rst_fault", 64'(ls_fault), 64'd0);
        chk("rst_wmask", 64'(mem_wmask), 64'd0);
        chk("rst_stall", 64'(ls_stall), 64'd0);
        step();
        rstn = 1'b1;
        step();

        // LB at 0x1003, ack in second REQ cycle
        run_access(1'b0, 3'b000, 64'h1003, 64'h0, 2, 64'h00000000_80000000,
                   64'hFFFFFFFF_FFFFFF80, 2'b00);
        chk("lb_stall_cycles", 64'(stall_cnt), 64'd3);
        chk("lb_done_at", 64'(done_at), 64'd3);
        chk("lb_req", 64'(cap_req), 64'd1);
        chk("lb_addr", cap_addr, 64'h1000);
        chk("lb_wmask", 64'(cap_wmask), 64'h00);
        step();
        @(negedge clk);
        chk("lb_done_pulse", 64'(ls_done), 64'd0);
        chk("lb_rdata_hold", ls_rdata, 64'hFFFFFFFF_FFFFFF80);
        step();

        // mem_ack while idle must be ignored
        mem_ack = 1'b1;
        @(negedge clk);
        chk("idle_ack_req", 64'(mem_req), 64'd0);
        step();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("idle_ack_done", 64'(ls_done), 64'd0);
        step();

        // SH of 0xABCD at 0x2006
        run_access(1'b1, 3'b001, 64'h2006, 64'hABCD, 1, 64'h0, 64'h0, 2'b00);
        chk("sh_addr", cap_addr, 64'h2000);
        chk("sh_wmask", 64'(cap_wmask), 64'hC0);
        chk("sh_wdata", cap_wdata, 64'hABCD0000_00000000);
        chk("sh_we", 64'(cap_we), 64'd1);
        chk("sh_done_at", 64'(done_at), 64'd2);
        step();

        // SW at 0x4
        run_access(1'b1, 3'b010, 64'h4, 64'hDEADBEEF, 1, 64'h0, 64'h0, 2'b00);
        chk("sw_wmask", 64'(cap_wmask), 64'hF0);
        chk("sw_wdata", cap_wdata, 64'hDEADBEEF_00000000);
        step();

        // LW misaligned at 0x1002
        run_access(1'b0, 3'b010, 64'h1002, 64'h0, 0, 64'h0, 64'h0, 2'b01);
        chk("lw_mis_done_at", 64'(done_at), 64'd1);
        chk("lw_mis_req", 64'(cap_req), 64'd0);
        step();

        // funct3=111 load is treated as misaligned
        run_access(1'b0, 3'b111, 64'h0, 64'h0, 0, 64'h0, 64'h0, 2'b01);
        chk("f111_done_at", 64'(done_at), 64'd1);
        step();

        // LD with no ack: timeout after 4 REQ cycles
        run_access(1'b0, 3'b011, 64'h8, 64'h0, 0, 64'h0, 64'h0, 2'b10);
        chk("ld_to_done_at", 64'(done_at), 64'd5);
        chk("ld_to_req_after", 64'(done_req), 64'd0);
        chk("ld_to_stall", 64'(stall_cnt), 64'd5);
        step();

        // Ack in the same cycle the counter expires wins over the timeout
        run_access(1'b0, 3'b011, 64'h10, 64'h0, 4, 64'h01234567_89ABCDEF,
                   64'h01234567_89ABCDEF, 2'b00);
        chk("ld_edge_done_at", 64'(done_at), 64'd5);
        step();

        // LWU at 0x3004; ls_valid raised during DONE must be ignored
        run_access(1'b0, 3'b110, 64'h3004, 64'h0, 1, 64'h87654321_00000000,
                   64'h00000000_87654321, 2'b00);
        ls_we     = 1'b0;
        ls_funct3 = 3'b011;
        ls_addr   = 64'h100;
        ls_valid  = 1'b1;
        step();
        ls_valid = 1'b0;
        @(negedge clk);
        chk("done_valid_req", 64'(mem_req), 64'd0);
        chk("done_valid_stall", 64'(ls_stall), 64'd0);
        step();

        // LH at 0x1006
        run_access(1'b0, 3'b001, 64'h1006, 64'h0, 1, 64'h8001_0000_0000_0000,
                   64'hFFFFFFFF_FFFF8001, 2'b00);
        step();

        // Reset during REQ, with mem_ack asserted across it
        ls_we     = 1'b1;
        ls_funct3 = 3'b011;
        ls_addr   = 64'h5000;
        ls_wdata  = 64'h1122334455667788;
        ls_valid  = 1'b1;
        step();
        ls_valid = 1'b0;
        @(negedge clk);
        chk("rreq_req", 64'(mem_req), 64'd1);
        rstn    = 1'b0;
        mem_ack = 1'b1;
        step();
        rstn = 1'b1;
        @(negedge clk);
        chk("rreq_req_0", 64'(mem_req), 64'd0);
        chk("rreq_done", 64'(ls_done), 64'd0);
        chk("rreq_stall", 64'(ls_stall), 64'd0);
        chk("rreq_addr", mem_addr, 64'h0);
        chk("rreq_wdata", mem_wdata, 64'h0);
        chk("rreq_wmask", 64'(mem_wmask), 64'd0);
        chk("rreq_we", 64'(mem_we), 64'd0);
        chk("rreq_rdata", ls_rdata, 64'h0);
        chk("rreq_fault", 64'(ls_fault), 64'd0);
        step();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("rreq_done_after", 64'(ls_done), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the maximum number of cycles to wait for mem_ack before aborting.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 SHALL have port rstn, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port ls_valid, input, 1 bit: the core requests a load or store.
REQ-005 SHALL have port ls_we, input, 1 bit: 1 = store, 0 = load.
REQ-006 SHALL have port ls_funct3, input, 3 bits: RISC-V width/sign code (000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU; stores use the low 2 bits).
REQ-007 SHALL have port ls_addr, input, 64 bits: byte address from the ALU.
REQ-008 SHALL have port ls_wdata, input, 64 bits: store data from the register file, right-aligned.
REQ-009 SHALL have port ls_done, output, 1 bit: one-cycle pulse when the access completes or faults.
REQ-010 SHALL have port ls_rdata, output, 64 bits: load result, extended per funct3, feeding the writeback MEM input.
REQ-011 SHALL have port ls_stall, output, 1 bit: holds the pipeline while an access is pending.
REQ-012 SHALL have port ls_fault, output, 2 bits: 00 none, 01 misaligned, 10 timeout; valid while ls_done=1.
REQ-013 SHALL have port mem_req, output, 1 bit: memory request.
REQ-014 SHALL have port mem_we, output, 1 bit: memory write enable.
REQ-015 SHALL have port mem_addr, output, 64 bits: ls_addr with bits [2:0] forced to 0.
REQ-016 SHALL have port mem_wdata, output, 64 bits: store data shifted left by 8*addr[2:0].
REQ-017 SHALL have port mem_wmask, output, 8 bits: byte-enable mask.
REQ-018 SHALL have port mem_ack, input, 1 bit: memory response; in the same cycle, mem_rdata is valid for reads.
REQ-019 SHALL have port mem_rdata, input, 64 bits: doubleword read data.

Function
REQ-020 SHALL implement the FSM states IDLE, REQ, DONE.
REQ-021 IDLE with ls_valid=1 and a misaligned address SHALL go to DONE with ls_fault=01 and SHALL NOT assert mem_req.
- Misaligned: halfword with addr[0]!=0; word with addr[1:0]!=0; doubleword with addr[2:0]!=0.
REQ-022 IDLE with ls_valid=1 and an aligned address SHALL go to REQ.
- On that edge, SHALL latch we, funct3, addr[2:0], mem_addr, mem_wdata and mem_wmask.
- SHALL clear the timeout counter.
REQ-023 In REQ, mem_req SHALL be 1 and all mem_* outputs SHALL hold stable until mem_ack.
REQ-024 REQ with mem_ack=1 SHALL go to DONE and SHALL register the extracted load data.
REQ-025 REQ with the timeout counter reaching TIMEOUT and no mem_ack SHALL go to DONE with ls_fault=10.
REQ-026 A mem_ack arriving in the same cycle the counter reaches TIMEOUT SHALL take priority: no fault.
REQ-027 DONE SHALL assert ls_done for exactly one cycle and then return to IDLE.
REQ-028 ls_stall SHALL equal (state==IDLE && ls_valid) || state==REQ, and SHALL be 0 in DONE.
REQ-029 mem_wmask SHALL be (0x01, 0x03, 0x0F, 0xFF) per width, shifted left by addr[2:0]; for loads it SHALL be 0.
REQ-030 Load extraction SHALL shift mem_rdata right by 8*addr[2:0], take 8/16/32/64 bits, then sign- or zero-extend to 64 bits per funct3.
REQ-031 ls_funct3=111 on a load SHALL be treated as misaligned (fault 01).
REQ-032 ls_rdata SHALL hold its last value until the next load completes, and SHALL be 0 after a store or a fault.
REQ-033 ls_valid in DONE SHALL be ignored; the core re-presents the access in IDLE.
REQ-034 mem_ack outside REQ SHALL be ignored.

Reset
REQ-035 With rstn=0 at a clock edge, the FSM SHALL enter IDLE, and the counter, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, ls_done, ls_rdata and ls_fault SHALL all be 0.
REQ-036 Reset asserted in REQ SHALL abort the access with no ls_done pulse and mem_req=0 on the next cycle.

Verification
REQ-037 LB at addr 0x1003, mem_rdata=0x00000000_80000000, ack after 2 cycles -> ls_rdata=0xFFFFFFFF_FFFFFF80, ls_done 1 cycle, stall 3 cycles.
REQ-038 SH of ls_wdata=0xABCD at 0x2006 -> mem_addr=0x2000, mem_wmask=0xC0, mem_wdata=0xABCD0000_00000000, mem_we=1.
REQ-039 LW at 0x1002 -> ls_fault=01, no mem_req, ls_done in the next cycle.
REQ-040 LD with mem_ack never asserted, TIMEOUT=4 -> ls_fault=10 after 4 REQ cycles, mem_req then 0.
REQ-041 LWU at 0x3004, mem_rdata=0x87654321_00000000 -> ls_rdata=0x00000000_87654321.
REQ-042 rstn=0 during REQ, then mem_ack pulsed -> no ls_done, state IDLE, all outputs 0.
